fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the single-cycle RISC-V core. It holds the architectural PC, fetches each instruction over a request/grant/response instruction-memory port, and presents the instruction to decode. It also drives pc_plus4 into pc_mux and loads PCNext back from pc_mux when the core retires the instruction. It stalls cleanly on memory latency, and faults on a misaligned next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, equals pc.
- imem_gnt  input  1  memory accepted request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  instruction word.
- instr  output  32  registered instruction to decode.
- instr_valid  output  1  instr and pc are valid.
- pc  output  32  PC of instr.
- pc_plus4  output  32  pc + 4, to pc_mux.
- pc_next  input  32  PCNext from pc_mux.
- core_ready  input  1  core retires instr this cycle (effective only when instr_valid).
- fault  output  1  sticky misaligned-PC fault.
- fault_pc  output  32  offending pc_next value.
- instret  output  32  retired-instruction count.

## Operation
- Five states:
  - IDLE: after reset, unconditionally goes to REQ on the next edge.
  - REQ: imem_req=1. On imem_gnt, go to WAIT.
  - WAIT: on imem_rvalid, instr <= imem_rdata and go to HOLD.
  - HOLD: instr_valid=1. On core_ready:
    - pc <= pc_next and instret <= instret+1.
    - If pc_next[1:0]!=0: fault <= 1, fault_pc <= pc_next, go to FAULT; pc is not updated.
    - Otherwise go to REQ.
  - FAULT: terminal until reset. imem_req=0 and instr_valid=0.
- Outputs:
  - imem_req is high only in REQ.
  - imem_addr = pc, stable for as long as imem_req is high without a grant.
  - instr_valid is high only in HOLD.
  - pc_plus4 = pc + 32'd4 (combinational), modulo 2^32.
- Ignored or dropped inputs:
  - imem_rvalid outside WAIT is ignored.
  - imem_gnt outside REQ is ignored.
  - core_ready outside HOLD is ignored.
- Arithmetic: instret wraps from 32'hFFFF_FFFF to 0. pc wraps naturally via pc_next.
- Async reset mid-transaction: state returns to IDLE, and any response arriving later is discarded (state is not WAIT).

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP).
  - imem_req=0, instr_valid=0, fault=0, fault_pc=0, instret=0.
- Cycle 1 after reset deassertion: imem_req=1.
- Latency:
  - imem_rvalid must arrive no earlier than the cycle after imem_gnt.
  - Minimum 3 cycles per instruction: gnt (REQ), rvalid (WAIT), ready (HOLD).
  - instr_valid rises the cycle after rvalid.
  - pc and instret update on the core_ready edge.
  - imem_req rises the cycle after core_ready.
- Back-pressure: instr, pc and pc_plus4 hold steady for any number of HOLD cycles with core_ready=0.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD, FAULT).
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - PC_INCR=32'd4.
- No sub-module needed. The FSM, PC register, instruction register and instret counter all live in fetch_ctrl. pc_mux remains a separate instance in the core top.

## Test plan
- Reset then straight-line fetch:
  - Stimulus: RESET_PC=0, memory grants immediately, rvalid one cycle later, core_ready=1.
  - Response: fetch addresses 0, 4, 8; instret=3 after 9 cycles; pc_plus4=pc+4 throughout.
- Back-pressure and memory stall:
  - Stimulus: gnt delayed 3 cycles, then core_ready held low 5 cycles.
  - Response: imem_addr stable through the grant delay; instr and pc unchanged while core_ready is low; instret does not increment.
- Taken branch:
  - Stimulus: pc_next=32'h0000_0100 at retire of pc=8.
  - Response: next imem_addr=32'h100; instret increments by 1.
- Misaligned target:
  - Stimulus: pc_next=32'h0000_0102.
  - Response: fault=1 and fault_pc=32'h102 from the next cycle; imem_req stays 0 permanently; pc stays at the old value.
- Reset mid-WAIT:
  - Stimulus: assert rst after gnt, pulse rvalid two cycles after release.
  - Response: the stray rvalid is ignored; the first fetch after release is at RESET_PC; instret=0.
- Counter wrap:
  - Stimulus: force instret=32'hFFFF_FFFF, then retire one instruction.
  - Response: instret=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INCR   = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_t;

    // A target is fetchable only if it is word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, fetches over a req/gnt/rvalid
// port, holds the instruction for decode and faults on a misaligned next PC.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] pc_next,
    input  logic            core_ready,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    output logic [XLEN-1:0] instret
);

    fetch_state_t state;

    // Address is the PC itself, so it cannot move while a request is pending.
    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_INCR;

    // FSM with registered handshake outputs; each output is set on entry to its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            fault_pc    <= '0;
            instret     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt) begin
                        state    <= S_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state       <= S_HOLD;
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (core_ready) begin
                        instret     <= instret + XLEN'(1);
                        instr_valid <= 1'b0;
                        if (is_misaligned(pc_next)) begin
                            state    <= S_FAULT;
                            fault    <= 1'b1;
                            fault_pc <= pc_next;
                        end else begin
                            state    <= S_REQ;
                            pc       <= pc_next;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + randomized bench for fetch_ctrl against a transaction-level model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next = '0;
    logic        core_ready = 1'b0;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] instret;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_next),
        .core_ready  (core_ready),
        .fault       (fault),
        .fault_pc    (fault_pc),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Architectural model: PC of the instruction in flight, retire count, fault record.
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instret = 32'h0;
    logic [31:0] m_fpc     = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One instruction: gd stall cycles before grant, rd before rvalid, hd before retire.
    task automatic fetch_one(input int gd, input int rd, input int hd,
                             input logic [31:0] npc, input bit wrap);
        logic [31:0] data;
        data = $urandom;
        for (int i = 0; i <= gd; i++) begin
            chk("req_high", 32'(imem_req), 32'd1);
            chk("req_addr", imem_addr, m_pc);
            chk("req_ivalid", 32'(instr_valid), 32'd0);
            imem_gnt    = (i == gd);
            imem_rvalid = 1'($urandom);
            core_ready  = 1'($urandom);
            imem_rdata  = $urandom;
            @(negedge clk);
        end
        for (int j = 0; j <= rd; j++) begin
            chk("wait_req", 32'(imem_req), 32'd0);
            chk("wait_ivalid", 32'(instr_valid), 32'd0);
            imem_gnt    = 1'($urandom);
            imem_rvalid = (j == rd);
            imem_rdata  = (j == rd) ? data : $urandom;
            core_ready  = 1'($urandom);
            @(negedge clk);
        end
        for (int k = 0; k <= hd; k++) begin
            chk("hold_ivalid", 32'(instr_valid), 32'd1);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_instr", instr, data);
            chk("hold_pc", pc, m_pc);
            chk("hold_pc4", pc_plus4, m_pc + 32'd4);
            chk("hold_instret", instret, m_instret);
            if (wrap && k == 0) begin
                force dut.instret = 32'hFFFF_FFFF;
                #1;
                release dut.instret;
                m_instret = 32'hFFFF_FFFF;
                chk("wrap_preset", instret, m_instret);
            end
            imem_gnt    = 1'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            core_ready  = (k == hd);
            pc_next     = (k == hd) ? npc : $urandom;
            @(negedge clk);
        end
        core_ready  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        m_instret   = m_instret + 32'd1;
        if (npc[1:0] != 2'b00) m_fpc = npc;
        else m_pc = npc;
    endtask

    initial begin
        logic [31:0] npc;

        // Reset values.
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_ivalid", 32'(instr_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_instret", instret, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Straight line 0,4,8 with a taken branch to 0x100 at retire of pc=8.
        fetch_one(0, 0, 0, 32'h4, 1'b0);
        fetch_one(0, 0, 0, 32'h8, 1'b0);
        fetch_one(0, 0, 0, 32'h100, 1'b0);
        chk("instret_after_3", instret, 32'd3);
        chk("branch_addr", imem_addr, 32'h100);

        // Grant delayed 3 cycles, then decode back-pressure for 5 cycles.
        fetch_one(3, 0, 5, 32'h104, 1'b0);
        chk("bp_instret", instret, 32'd4);

        // PC at the top of the address space: pc_plus4 wraps.
        fetch_one(0, 1, 0, 32'hFFFF_FFFC, 1'b0);
        chk("top_pc4", pc_plus4, 32'h0);
        fetch_one(1, 0, 1, 32'h0, 1'b0);

        // Randomized stretch with aligned targets.
        for (int n = 0; n < 25; n++) begin
            npc = $urandom;
            npc[1:0] = 2'b00;
            if ($urandom_range(1, 0) == 1) npc = m_pc + 32'd4;
            fetch_one($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(4, 0), npc, 1'b0);
        end

        // Retire counter wraps.
        fetch_one(0, 0, 2, m_pc + 32'd4, 1'b1);
        chk("instret_wrap", instret, 32'h0);

        // Reset while waiting for the response; late rvalid must be ignored.
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        chk("mid_wait_req", 32'(imem_req), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instret", instret, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h0;
        m_instret = 32'h0;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("stray_ivalid", 32'(instr_valid), 32'd0);
        chk("stray_instr", instr, 32'h0000_0013);
        fetch_one(0, 0, 0, 32'h4, 1'b0);
        fetch_one(0, 0, 0, 32'h8, 1'b0);

        // Misaligned target: fault is terminal.
        fetch_one(0, 0, 1, 32'h102, 1'b0);
        for (int c = 0; c < 8; c++) begin
            chk("flt_fault", 32'(fault), 32'd1);
            chk("flt_fault_pc", fault_pc, m_fpc);
            chk("flt_req", 32'(imem_req), 32'd0);
            chk("flt_ivalid", 32'(instr_valid), 32'd0);
            chk("flt_pc", pc, m_pc);
            chk("flt_instret", instret, m_instret);
            imem_gnt    = 1'($urandom);
            imem_rvalid = 1'($urandom);
            core_ready  = 1'($urandom);
            pc_next     = $urandom;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
